// File: rtl/bip_program_loader.sv
// Assembles a little-endian byte stream into 16-bit BIP instructions and writes them
// to consecutive program memory addresses until a Halt is written or memory fills.
module bip_program_loader #(
    parameter int NB_DATA            = 16,
    parameter int NB_BYTE            = 8,
    parameter int NB_OPCODE          = 5,
    parameter int N_ADDR             = 2048,
    parameter int LOG2_N_INSMEM_ADDR = 11
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic [NB_BYTE-1:0]              i_rx_data,
    input  logic                            i_rx_valid,
    output logic                            o_ready,
    output logic                            o_wr_en,
    output logic [LOG2_N_INSMEM_ADDR-1:0]   o_wr_addr,
    output logic [NB_DATA-1:0]              o_wr_data,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_error,
    output logic [LOG2_N_INSMEM_ADDR:0]     o_word_count
);

    localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR = LOG2_N_INSMEM_ADDR'(N_ADDR - 1);

    typedef enum logic [2:0] {IDLE, WAIT_LO, WAIT_HI, WRITE, DONE} state_t;

    state_t                          state, state_next;
    logic [NB_BYTE-1:0]              lo_byte, lo_byte_next;
    logic [LOG2_N_INSMEM_ADDR-1:0]   addr, addr_next;
    logic                            ready_next, wr_en_next, busy_next, done_next, error_next;
    logic [LOG2_N_INSMEM_ADDR-1:0]   wr_addr_next;
    logic [NB_DATA-1:0]              wr_data_next;
    logic [LOG2_N_INSMEM_ADDR:0]     word_count_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            lo_byte      <= '0;
            addr         <= '0;
            o_ready      <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_count <= '0;
        end else begin
            state        <= state_next;
            lo_byte      <= lo_byte_next;
            addr         <= addr_next;
            o_ready      <= ready_next;
            o_wr_en      <= wr_en_next;
            o_wr_addr    <= wr_addr_next;
            o_wr_data    <= wr_data_next;
            o_busy       <= busy_next;
            o_done       <= done_next;
            o_error      <= error_next;
            o_word_count <= word_count_next;
        end
    end

    // Outputs are registered, so the status flags are derived from the next state.
    always_comb begin
        state_next      = state;
        lo_byte_next    = lo_byte;
        addr_next       = addr;
        wr_addr_next    = o_wr_addr;
        wr_data_next    = o_wr_data;
        done_next       = o_done;
        error_next      = o_error;
        word_count_next = o_word_count;

        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    addr_next       = '0;
                    word_count_next = '0;
                    done_next       = 1'b0;
                    error_next      = 1'b0;
                    state_next      = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (i_rx_valid) begin
                    lo_byte_next = i_rx_data;
                    state_next   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_rx_valid) begin
                    wr_addr_next = addr;
                    wr_data_next = {i_rx_data, lo_byte};
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                word_count_next = o_word_count + (LOG2_N_INSMEM_ADDR+1)'(1);
                if (o_wr_data[NB_DATA-1 -: NB_OPCODE] == '0) begin
                    done_next  = 1'b1;
                    error_next = 1'b0;
                    state_next = DONE;
                end else if (addr == LAST_ADDR) begin
                    done_next  = 1'b1;
                    error_next = 1'b1;
                    state_next = DONE;
                end else begin
                    addr_next  = addr + LOG2_N_INSMEM_ADDR'(1);
                    state_next = WAIT_LO;
                end
            end
            default: state_next = IDLE;
        endcase

        ready_next = (state_next == WAIT_LO) || (state_next == WAIT_HI);
        busy_next  = ready_next || (state_next == WRITE);
        wr_en_next = (state_next == WRITE);
    end

endmodule

// File: tb/tb_bip_program_loader.sv
// Randomized scoreboard bench for bip_program_loader: a transaction-level model queues
// the expected memory writes and a monitor checks each write pulse the DUT produces.
module tb_bip_program_loader;

    localparam int NA = 8;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          ready, wr_en, busy, done, error;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [AW:0]   word_count;

    bip_program_loader #(
        .NB_DATA(16), .NB_BYTE(8), .NB_OPCODE(5), .N_ADDR(NA), .LOG2_N_INSMEM_ADDR(AW)
    ) dut (
        .i_clock(clock), .i_reset(reset), .i_start(start), .i_rx_data(rx_data),
        .i_rx_valid(rx_valid), .o_ready(ready), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_busy(busy), .o_done(done), .o_error(error),
        .o_word_count(word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_compared   = 0;
    int  n_mismatched = 0;

    // Reference model of one load: address/count/termination from the loader's rules.
    int  m_addr, m_count;
    bit  m_done, m_error;

    task automatic check_value(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_start();
        m_addr = 0; m_count = 0; m_done = 0; m_error = 0;
    endfunction

    function automatic void model_word(input logic [15:0] d);
        wr_t w;
        w.addr = m_addr;
        w.data = d;
        exp_q.push_back(w);
        m_count++;
        if ((d >> 11) == 0) begin
            m_done = 1; m_error = 0;
        end else if (m_count == NA) begin
            m_done = 1; m_error = 1;
        end else begin
            m_addr++;
        end
    endfunction

    // Monitor: every write pulse must match the oldest outstanding expectation.
    logic prev_wr_en = 1'b0;
    always @(negedge clock) begin
        if (wr_en) begin
            check_value("wr_en_single_cycle", int'(prev_wr_en), 0);
            if (exp_q.size() == 0) begin
                check_value("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check_value("wr_addr", int'(wr_addr), w.addr);
                check_value("wr_data", int'(wr_data), int'(w.data));
            end
        end
        prev_wr_en = wr_en;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        int waited = 0;
        tick($urandom_range(0, 2));
        while (!ready && waited < 20) begin
            tick(1);
            waited++;
        end
        if (!ready) begin
            check_value("ready_timeout", int'(ready), 1);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input bit poke_in_write);
        apply_stimulus(d[7:0]);
        apply_stimulus(d[15:8]);
        model_word(d);
        if (poke_in_write) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
            tick(1);
            rx_valid = 1'b0;
        end
    endtask

    task automatic start_load(input bit with_byte);
        start    = 1'b1;
        rx_valid = with_byte;
        rx_data  = 8'hA5;
        tick(1);
        start    = 1'b0;
        rx_valid = 1'b0;
        model_start();
        check_value("busy_after_start", int'(busy), 1);
        check_value("done_cleared", int'(done), 0);
        check_value("count_cleared", int'(word_count), 0);
    endtask

    task automatic check_output();
        int waited = 0;
        while (!done && waited < 20) begin
            tick(1);
            waited++;
        end
        tick(2);
        check_value("done", int'(done), int'(m_done));
        check_value("error", int'(error), int'(m_error));
        check_value("word_count", int'(word_count), m_count);
        check_value("busy_idle", int'(busy), 0);
        check_value("ready_idle", int'(ready), 0);
        check_value("pending_writes", exp_q.size(), 0);
    endtask

    function automatic logic [15:0] rand_word(input bit halt);
        logic [15:0] d;
        d = 16'($urandom);
        if (halt) d[15:11] = 5'd0;
        else if (d[15:11] == 5'd0) d[11] = 1'b1;
        return d;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        model_start();
        tick(3);
        reset = 1'b0;
        tick(1);
        check_value("rst_busy", int'(busy), 0);
        check_value("rst_ready", int'(ready), 0);
        check_value("rst_done", int'(done), 0);
        check_value("rst_error", int'(error), 0);
        check_value("rst_count", int'(word_count), 0);
        check_value("rst_wr_addr", int'(wr_addr), 0);
        check_value("rst_wr_data", int'(wr_data), 0);

        // Bytes in IDLE are ignored.
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i + 1);
            tick(1);
        end
        rx_valid = 1'b0;
        check_value("idle_busy", int'(busy), 0);
        check_value("idle_count", int'(word_count), 0);

        // Basic load.
        start_load(0);
        send_word(16'h1001, 0);
        send_word(16'h2802, 0);
        send_word(16'h0000, 0);
        check_output();

        // Halt as the very first word; start with a simultaneous dropped byte.
        start_load(1);
        send_word(16'h0005, 0);
        check_output();

        // Fill memory without a Halt, then stray bytes must not write.
        start_load(0);
        for (int i = 0; i < NA; i++) send_word(16'h0801, 0);
        check_output();
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'h33;
            tick(1);
        end
        rx_valid = 1'b0;
        check_value("ovf_done_held", int'(done), 1);
        check_value("ovf_count_held", int'(word_count), NA);

        // Start while busy and a byte during WRITE are both ignored.
        start_load(0);
        send_word(16'h1234, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send_word(16'h4321, 1);
        send_word(16'h00FF, 0);
        check_output();

        // Reset after the low byte of the second word: no write, outputs clear.
        start_load(0);
        send_word(16'h1234, 0);
        apply_stimulus(8'h56);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_value("mid_rst_busy", int'(busy), 0);
        check_value("mid_rst_count", int'(word_count), 0);
        check_value("mid_rst_addr", int'(wr_addr), 0);
        check_value("mid_rst_data", int'(wr_data), 0);
        tick(3);
        check_value("mid_rst_pending", exp_q.size(), 0);
        start_load(0);
        send_word(16'h0801, 0);
        send_word(16'h0802, 0);
        send_word(16'h0003, 0);
        check_output();

        // Randomized loads, some long enough to overflow.
        for (int it = 0; it < 12; it++) begin
            int n;
            n = $urandom_range(1, NA + 2);
            start_load($urandom_range(0, 1) == 1);
            for (int k = 0; k < n && !m_done; k++) begin
                send_word(rand_word(k == n - 1), $urandom_range(0, 3) == 0);
            end
            check_output();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bip_program_loader.md
Name: bip_program_loader

Overview:
Writer-side counterpart of the BIP program memory. Receives a byte stream, such as from the UART receiver, and assembles 16-bit instructions from pairs of bytes, low byte first. It writes each instruction into the program memory write port at consecutive addresses starting at 0. Loading stops after a Halt instruction (opcode 00000) is written, or when the memory is full.

Parameters:
NB_DATA, 16, instruction width in bits (must be 2*NB_BYTE)
NB_BYTE, 8, width of the incoming byte stream
NB_OPCODE, 5, opcode field width, located at [NB_DATA-1 -: NB_OPCODE]
N_ADDR, 2048, number of program memory words
LOG2_N_INSMEM_ADDR, 11, address width

Ports:
i_clock  in  1  system clock; every register updates on the rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  single-cycle pulse that arms a load starting at address 0
i_rx_data  in  NB_BYTE  incoming byte
i_rx_valid  in  1  single-cycle strobe; i_rx_data is valid in this cycle
o_ready  out  1  high when a byte will be accepted this cycle
o_wr_en  out  1  program memory write enable
o_wr_addr  out  LOG2_N_INSMEM_ADDR  program memory write address
o_wr_data  out  NB_DATA  program memory write data
o_busy  out  1  high while a load is in progress
o_done  out  1  high once a load has terminated; held until the next i_start or reset
o_error  out  1  high if the load terminated because memory was full with no Halt written
o_word_count  out  LOG2_N_INSMEM_ADDR+1  number of words written in the current or last load

Behaviour:
- Reset: on i_reset=1 at a clock edge, state goes to IDLE and every output, the address counter and the byte registers clear to 0. This applies in any state. A reset in mid-load performs no further write and leaves memory contents untouched.
- All outputs are registered.
- States: IDLE, WAIT_LO, WAIT_HI, WRITE, DONE.
- IDLE:
  - o_busy=0, o_ready=0; i_rx_valid is ignored.
  - On i_start=1: clear the address counter, o_word_count, o_done and o_error; go to WAIT_LO.
- WAIT_LO:
  - o_busy=1, o_ready=1.
  - On i_rx_valid=1: latch i_rx_data into the low byte; go to WAIT_HI.
- WAIT_HI:
  - o_busy=1, o_ready=1.
  - On i_rx_valid=1: latch the high byte; go to WRITE.
- WRITE:
  - Lasts exactly one cycle. o_wr_en=1, o_wr_addr=current address, o_wr_data={high byte, low byte}; o_ready=0.
  - A byte presented in this cycle is dropped. The upstream must respect o_ready.
  - o_wr_en therefore rises the cycle after the high byte is accepted and is never high for more than one cycle per word.
  - On exit, o_word_count is incremented.
  - Transition priority:
    1. Opcode of the written word = 0 (Halt): go to DONE with o_done=1, o_error=0.
    2. Else, address = N_ADDR-1: go to DONE with o_done=1, o_error=1.
    3. Else: address+1, go to WAIT_LO.
  - The address never wraps.
- DONE:
  - o_busy=0, o_ready=0, o_wr_en=0; o_done and o_error held.
  - i_start=1 re-arms exactly as in IDLE.
- i_start while o_busy=1 is ignored; no restart occurs.
- i_start and i_rx_valid in the same cycle in IDLE/DONE: the start is taken, the byte is dropped.
- o_wr_addr and o_wr_data hold their last values when o_wr_en=0.
- Simultaneous i_reset and i_start: reset wins.

Test Plan:
- Basic load: i_start, then bytes 01,10, 02,28, 00,00 -> exactly three write pulses: (addr 0, 0x1001), (1, 0x2802), (2, 0x0000); o_done=1, o_error=0, o_word_count=3, o_busy=0.
- Halt first: bytes 05,00 -> one write (0, 0x0005)? No: 0x0005 has opcode 0, so it is a Halt -> o_done=1 after one write, o_word_count=1.
- Overflow, with N_ADDR=4, LOG2=2: feed 4 non-Halt words (0x0801 repeated) -> writes at addresses 0..3, then o_done=1, o_error=1, o_word_count=4; further bytes cause no o_wr_en.
- Ignored inputs: bytes while in IDLE, i_start while busy after one word, and a byte presented during WRITE -> none of these produce a write or restart; next words continue at the correct address.
- Reset mid-load: reset after the low byte of word 2 -> no write occurs; all outputs return to 0; a fresh i_start and a 3-word load writes from address 0.
- Reload: after DONE, i_start and 2 words ending with Halt -> o_done clears for the load, then sets again; o_word_count=2; addresses restart at 0.
